// File: rtl/spi_send_arbiter_pkg.sv
// Shared types and constants for the SPI send-path stream arbiter.
package spi_send_arbiter_pkg;

    localparam int unsigned MAX_SRC  = 4;
    localparam int unsigned IDX_W    = $clog2(MAX_SRC);
    localparam logic [7:0]  HDR_BASE = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/spi_send_arbiter_if.sv
// Bundle of source/sink stream signals and status outputs of the arbiter.
interface spi_send_arbiter_if #(
    parameter int unsigned N_SRC = 4
);
    logic [N_SRC*8-1:0] s_axis_rdata;
    logic [N_SRC-1:0]   s_axis_rvalid;
    logic [N_SRC-1:0]   s_axis_rready;
    logic [N_SRC-1:0]   s_axis_rlast;
    logic [N_SRC-1:0]   src_enable;
    logic [7:0]         m_axis_rdata;
    logic               m_axis_rvalid;
    logic               m_axis_rready;
    logic               m_axis_rlast;
    logic               busy;
    logic [1:0]         grant_id;
    logic [15:0]        pkt_cnt;

    // slave: the arbiter's view
    modport slave (
        input  s_axis_rdata, s_axis_rvalid, s_axis_rlast, src_enable, m_axis_rready,
        output s_axis_rready, m_axis_rdata, m_axis_rvalid, m_axis_rlast,
               busy, grant_id, pkt_cnt
    );

    // master: the environment driving sources and sinking the merged stream
    modport master (
        output s_axis_rdata, s_axis_rvalid, s_axis_rlast, src_enable, m_axis_rready,
        input  s_axis_rready, m_axis_rdata, m_axis_rvalid, m_axis_rlast,
               busy, grant_id, pkt_cnt
    );
endinterface

// File: rtl/spi_send_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo N.
module rr_arbiter
    import spi_send_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    int unsigned idx;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/spi_send_arbiter.sv
// Packet-level round-robin merge of N_SRC byte streams, with optional source-ID header.
module spi_send_arbiter
    import spi_send_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC  = 4,
    parameter bit          HDR_EN = 1'b1
) (
    input logic               axis_aclk,
    input logic               axis_areset,
    spi_send_arbiter_if.slave bus
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] rready;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;
    logic [7:0]       sel_data, m_data;
    logic             sel_valid, sel_last;
    logic             m_valid, m_last, busy;

    assign req = bus.s_axis_rvalid & bus.src_enable;

    rr_arbiter #(.N(N_SRC)) u_rr (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_data  = bus.s_axis_rdata[i*8 +: 8];
                sel_valid = bus.s_axis_rvalid[i];
                sel_last  = bus.s_axis_rlast[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        rready    = '0;
        m_data    = '0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_idx;
                    state_d = HDR_EN ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                busy    = 1'b1;
                m_data  = HDR_BASE | {{(8-IDX_W){1'b0}}, grant_q};
                m_valid = 1'b1;
                if (bus.m_axis_rready) state_d = ST_DATA;
            end
            ST_DATA: begin
                busy    = 1'b1;
                m_data  = sel_data;
                m_valid = sel_valid;
                m_last  = sel_last;
                for (int unsigned i = 0; i < N_SRC; i++) begin
                    if (grant_q == IDX_W'(i)) rready[i] = bus.m_axis_rready;
                end
                // src_enable is not consulted here: a granted packet always runs to its last beat
                if (sel_valid && bus.m_axis_rready && sel_last) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = (grant_q == IDX_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign bus.s_axis_rready = rready;
    assign bus.m_axis_rdata  = m_data;
    assign bus.m_axis_rvalid = m_valid;
    assign bus.m_axis_rlast  = m_last;
    assign bus.busy          = busy;
    assign bus.grant_id      = grant_q;
    assign bus.pkt_cnt       = pkt_cnt_q;
endmodule

// File: doc/spi_send_arbiter.md
SPI_SEND_ARBITER -- requirements
Module: spi_send_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, number of requesting AXI4-Stream sources (2..4).
REQ-002 Parameter HDR_EN, default 1; 1 = insert one source-ID header byte before each packet, 0 = no header.
REQ-003 Port axis_aclk, input, 1, the single block clock; all logic is on its rising edge.
REQ-004 Port axis_areset, input, 1, reset; asynchronous and active-high.
REQ-005 Port s_axis_rdata, input, N_SRC*8, source data; byte k is at bits [8k+7:8k].
REQ-006 Port s_axis_rvalid, input, N_SRC, per-source valid.
REQ-007 Port s_axis_rready, output, N_SRC, per-source ready.
REQ-008 Port s_axis_rlast, input, N_SRC, per-source end-of-packet.
REQ-009 Port src_enable, input, N_SRC, per-source arbitration mask; 1 = eligible.
REQ-010 Port m_axis_rdata, output, 8, merged stream to the SPI send path.
REQ-011 Port m_axis_rvalid, output, 1, merged valid.
REQ-012 Port m_axis_rready, input, 1, downstream ready.
REQ-013 Port m_axis_rlast, output, 1, merged end-of-packet.
REQ-014 Port busy, output, 1, high while in HDR or DATA.
REQ-015 Port grant_id, output, 2, index of the granted source; valid while busy.
REQ-016 Port pkt_cnt, output, 16, count of completed output packets; wraps 0xFFFF->0.

Function
REQ-017 FSM states are IDLE, HDR and DATA.
REQ-018 IDLE: the request vector is s_axis_rvalid & src_enable; if it is non-zero, the block registers grant = first requester at or after rr_ptr, modulo N_SRC.
REQ-019 IDLE with a non-zero request vector goes to HDR when HDR_EN=1, else to DATA; with no request it stays in IDLE.
REQ-020 In IDLE all s_axis_rready are 0 and m_axis_rvalid is 0.
REQ-021 HDR: m_axis_rdata = 8'hA0 | grant, m_axis_rvalid = 1, m_axis_rlast = 0, all s_axis_rready = 0.
REQ-022 HDR holds its outputs until m_axis_rready = 1, then goes to DATA.
REQ-023 DATA is a combinational pass-through of the granted source: m_axis_rdata, m_axis_rvalid and m_axis_rlast follow that source, and s_axis_rready[grant] = m_axis_rready.
REQ-024 In DATA, s_axis_rready of every non-granted source is 0.
REQ-025 DATA ends on a transfer with rlast=1 (m_axis_rvalid & m_axis_rready & m_axis_rlast): go to IDLE, set rr_ptr = (grant+1) mod N_SRC, and increment pkt_cnt.
REQ-026 A single-beat packet (rlast on the first beat) is legal and ends DATA after that one transfer.
REQ-027 Arbitration is per packet; a packet is never interleaved with another source's data.
REQ-028 Latency: one idle cycle between packets; with HDR_EN=1 and m_axis_rready=1 the header appears one cycle after the request is seen and the first payload byte one cycle later.
REQ-029 Clearing src_enable[grant] during DATA does not abort the packet; the mask applies at the next arbitration only.
REQ-030 A granted source holding rvalid=0 in DATA stalls the block indefinitely; there is no timeout.
REQ-031 Simultaneous requests are resolved by round-robin from rr_ptr only; source index gives no fixed priority.

Reset
REQ-032 Asserting axis_areset, including mid-packet, immediately forces: state=IDLE, rr_ptr=0, grant=0, pkt_cnt=0.
REQ-033 During reset all outputs are 0: s_axis_rready, m_axis_rvalid, m_axis_rlast, m_axis_rdata, busy, grant_id.
REQ-034 A packet cut by reset is not resumed; arbitration restarts cleanly after reset is released.

Structure
REQ-035 A shared package holds the FSM state encoding, the header base constant 8'hA0 and the maximum source count 4.
REQ-036 One sub-module, rr_arbiter (request vector + pointer -> one-hot/index grant, combinational), is instantiated once.

Verification
REQ-037 Sources 0 and 2 each send a 3-byte packet starting in the same cycle, m_axis_rready=1 -> output A0,d0,d0,d0(last), idle cycle, A2,d2,d2,d2(last); pkt_cnt=2.
REQ-038 All 4 sources request continuously with 1-byte packets -> grant order 0,1,2,3,0; no source is granted twice before each other requester is granted once.
REQ-039 HDR_EN=0, source 1 sends a 1-byte packet 0x5A with last -> one output beat 0x5A, rlast=1, then IDLE; busy is high for exactly that beat.
REQ-040 m_axis_rready held at 0 for 5 cycles during HDR, then 1 -> header 0xA1 is stable for all 6 cycles and transfers once.
REQ-041 src_enable[3]=0 with source 3 valid -> source 3 is never granted; source 3 enabled mid-packet of source 0 -> source 3 is granted only after source 0's last.
REQ-042 Reset asserted on the 2nd payload byte, then released -> all outputs are 0 immediately, pkt_cnt=0, and the next request is granted from rr_ptr=0.
